console_tx: RTL and testbench

Memory-mapped serial console transmitter on the system wishbone bus: a bus slave that responds to CPU (MMU master) and DMA master accesses, buffers written bytes in an 8-entry FIFO, and serialises them 8N1, LSB-first, on a single output line. It sits beside the keyboard as a simple output IO device. It raises a level interrupt when its buffer drains.

---
 rtl/console_tx.sv | 204 ++++++++++++++++++++
 tb/tb_console_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/console_tx.sv
// console_tx: memory-mapped 8N1 serial console transmitter on the wishbone bus.
// Bytes written to DATA are queued in a DEPTH-entry FIFO and sent LSB first,
// one start bit (0), eight data bits, one stop bit (1), each DIV+1 clocks long.
//
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   s_cyc      - bus cycle request; s_we selects write (1) or read (0)
//   s_strb     - byte enables; s_addr[3:2] selects DATA/STATUS/CTRL/DIV
//   s_data_i   - write data; s_data_o read data (valid with s_ack, else 0)
//   s_ack      - one-cycle registered acknowledge
//   tx_o       - serial line, idles high
//   tx_irq     - registered level interrupt: irq_en & fifo empty & line idle
module console_tx #(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cyc,
  input  logic        s_we,
  input  logic [3:0]  s_strb,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_data_i,
  output logic        s_ack,
  output logic [31:0] s_data_o,
  output logic        tx_o,
  output logic        tx_irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             taken, push_req, push_ok, pop;
  logic             wr_ctrl, wr_div, rd_status;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow, busy;
  logic             enable, irq_en;
  logic [15:0]      div;
  logic [1:0]       state;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{s_addr[31:4], s_addr[1:0], s_data_i[31:16], s_strb[3:2]};

  // A transfer is taken only in the first cycle of a request; the ack cycle
  // that follows is never taken, so every side effect happens exactly once.
  assign taken     = s_cyc & ~s_ack;
  assign push_req  = taken & s_we & (s_addr[3:2] == 2'd0) & s_strb[0];
  assign wr_ctrl   = taken & s_we & (s_addr[3:2] == 2'd2) & s_strb[0];
  assign wr_div    = taken & s_we & (s_addr[3:2] == 2'd3);
  assign rd_status = taken & ~s_we & (s_addr[3:2] == 2'd1);

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign busy    = (state != ST_IDLE);
  assign bit_end = (baud_cnt == 16'd0);

  // Pop from IDLE, or at the very end of a stop bit so frames run back to back.
  assign pop     = enable & ~empty &
                   ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
  // A push into a full FIFO still fits if the serialiser pops in the same cycle.
  assign push_ok = push_req & (~full | pop);

  assign tx_o = (state == ST_START) ? 1'b0 :
                (state == ST_DATA)  ? shreg[0] : 1'b1;

  always_comb begin
    rd_data = '0;
    case (s_addr[3:2])
      2'd1: begin
        rd_data[CNT_W+3:4] = count;
        rd_data[3:0]       = {overflow, busy, full, empty};
      end
      2'd2:    rd_data[1:0]  = {irq_en, enable};
      2'd3:    rd_data[15:0] = div;
      default: rd_data       = '0;
    endcase
  end

  // Bus response: ack and read data are registered together; data is zero
  // outside the ack cycle and for writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ack    <= 1'b0;
      s_data_o <= '0;
    end else begin
      s_ack    <= taken;
      s_data_o <= (taken & ~s_we) ? rd_data : '0;
    end
  end

  // Control registers and the sticky overflow flag (cleared by a STATUS read).
  always_ff @(posedge clk) begin
    if (rst) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      div      <= DIV_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= s_data_i[0];
        irq_en <= s_data_i[1];
      end
      if (wr_div && s_strb[0]) div[7:0]  <= s_data_i[7:0];
      if (wr_div && s_strb[1]) div[15:8] <= s_data_i[15:8];
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (rd_status)           overflow <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= s_data_i[7:0];
  end

  // Serialiser. The baud counter reloads from div at each bit boundary, so a
  // divisor change lands cleanly on the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= div;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= div;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= div;
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg    <= mem[rd_ptr];
              baud_cnt <= div;
              state    <= ST_START;
            end else begin
              state    <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Interrupt when nothing is left to send and the line is idle.
  always_ff @(posedge clk) begin
    if (rst) tx_irq <= 1'b0;
    else     tx_irq <= irq_en & empty & ~busy;
  end

endmodule

// File: tb/tb_console_tx.sv
// tb_console_tx: self-checking bench for console_tx.
module tb_console_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cyc = 1'b0;
  logic        s_we = 1'b0;
  logic [3:0]  s_strb = 4'h0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_data_i = 32'h0;
  logic        s_ack;
  logic [31:0] s_data_o;
  logic        tx_o;
  logic        tx_irq;

  console_tx #(.DEPTH(DEPTH), .DIV_RST(16'd3)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_cyc    (s_cyc),
    .s_we     (s_we),
    .s_strb   (s_strb),
    .s_addr   (s_addr),
    .s_data_i (s_data_i),
    .s_ack    (s_ack),
    .s_data_o (s_data_o),
    .tx_o     (tx_o),
    .tx_irq   (tx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Line and interrupt history, indexed by cycle number.
  logic txlog  [0:4095];
  logic irqlog [0:4095];
  always @(negedge clk) begin
    if (cyc < 4096) begin
      txlog[cyc]  = tx_o;
      irqlog[cyc] = tx_irq;
    end
  end

  // Behavioural model: a byte queue, and the frame on the line described as a
  // 10-bit vector {stop, data, start} indexed by elapsed cycles / bit length.
  logic [7:0]  q[$];
  bit          m_valid = 1'b0;
  logic        m_en, m_irqen, m_ovf, act;
  logic [15:0] m_div;
  logic [9:0]  vec;
  int          off, blen;
  logic        exp_ack, exp_tx, exp_irq;
  logic [31:0] exp_data;
  logic        m_taken, m_last, m_pop, m_push, m_full_pre, m_nirq;
  logic [31:0] m_rd;
  logic [7:0]  m_byte;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_en = 0; m_irqen = 0; m_ovf = 0; act = 0;
      m_div = 16'd3; off = 0; blen = 4; vec = '1;
      exp_ack = 0; exp_data = 0; exp_irq = 0;
      m_valid = 1'b1;
    end else begin
      m_taken    = s_cyc & ~exp_ack;
      m_full_pre = (q.size() == DEPTH);
      m_rd = 0;
      case (s_addr[3:2])
        2'd1: begin
          m_rd[7:4] = 4'(q.size());
          m_rd[3]   = m_ovf;
          m_rd[2]   = act;
          m_rd[1]   = m_full_pre;
          m_rd[0]   = (q.size() == 0);
        end
        2'd2:    m_rd = {30'b0, m_irqen, m_en};
        2'd3:    m_rd = {16'b0, m_div};
        default: m_rd = 0;
      endcase
      m_nirq = m_irqen && (q.size() == 0) && !act;
      m_last = act && (off == 10 * blen - 1);
      m_pop  = m_en && (q.size() > 0) && (!act || m_last);
      m_push = m_taken && s_we && (s_addr[3:2] == 2'd0) && s_strb[0];
      if (m_pop) begin
        m_byte = q.pop_front();
        vec  = {1'b1, m_byte, 1'b0};
        off  = 0;
        act  = 1;
        blen = int'(m_div) + 1;
      end else if (m_last) begin
        act = 0;
      end else if (act) begin
        off++;
      end
      if (m_push) begin
        if (!m_full_pre || m_pop) q.push_back(s_data_i[7:0]);
        else m_ovf = 1;
      end
      if (m_taken && !s_we && s_addr[3:2] == 2'd1) m_ovf = 0;
      if (m_taken && s_we && s_addr[3:2] == 2'd2 && s_strb[0]) {m_irqen, m_en} = s_data_i[1:0];
      if (m_taken && s_we && s_addr[3:2] == 2'd3) begin
        if (s_strb[0]) m_div[7:0]  = s_data_i[7:0];
        if (s_strb[1]) m_div[15:8] = s_data_i[15:8];
      end
      exp_data = (m_taken && !s_we) ? m_rd : 32'h0;
      exp_ack  = m_taken;
      exp_irq  = m_nirq;
    end
    exp_tx = act ? vec[off / blen] : 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model s_ack", {31'b0, s_ack}, {31'b0, exp_ack});
      checkOutput("model s_data_o", s_data_o, exp_data);
      checkOutput("model tx_o", {31'b0, tx_o}, {31'b0, exp_tx});
      checkOutput("model tx_irq", {31'b0, tx_irq}, {31'b0, exp_irq});
    end
  end

  // One bus transfer; returns read data and the cycle in which it was taken.
  task automatic applyStimulus(input logic we, input logic [1:0] idx,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [31:0] rdata, output int taken_cyc);
    bit got = 0;
    s_cyc = 1'b1; s_we = we; s_addr = {28'h0, idx, 2'b00};
    s_data_i = data; s_strb = strb;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (s_ack) got = 1;
    end
    checkOutput("bus ack", {31'b0, s_ack}, 32'h1);
    rdata = s_data_o;
    taken_cyc = cyc - 1;
    s_cyc = 1'b0; s_we = 1'b0; s_strb = 4'h0;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  logic [31:0] rd;
  int t0, t1, t2, t3, t4, tc, zeros;
  logic [9:0]  a5_line   = 10'b1101001010;
  logic [19:0] pair_line = 20'b1000011110_1010101010;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("reset tx_o", {31'b0, tx_o}, 32'h1);
    checkOutput("reset tx_irq", {31'b0, tx_irq}, 32'h0);
    applyStimulus(1'b0, 2'd1, 32'h0, 4'hF, rd, t0);
    checkOutput("reset STATUS", rd, 32'h0000_0001);
    applyStimulus(1'b0, 2'd3, 32'h0, 4'hF, rd, t0);
    checkOutput("reset DIV", rd, 32'h0000_0003);

    // Single frame 0xA5 at DIV=3
    applyStimulus(1'b1, 2'd2, 32'h1, 4'h1, rd, t0);
    applyStimulus(1'b1, 2'd0, 32'hA5, 4'h1, rd, t0);
    wait_cycle(t0 + 45);
    checkOutput("A5 before start", {31'b0, txlog[t0 + 1]}, 32'h1);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++)
        checkOutput($sformatf("A5 bit%0d cyc%0d", k, j),
                    {31'b0, txlog[t0 + 2 + 4 * k + j]}, {31'b0, a5_line[k]});
    checkOutput("A5 idle after", {31'b0, txlog[t0 + 42]}, 32'h1);

    // Back-to-back frames at DIV=0
    applyStimulus(1'b1, 2'd3, 32'h0, 4'h3, rd, t0);
    applyStimulus(1'b1, 2'd0, 32'h55, 4'h1, rd, t1);
    applyStimulus(1'b1, 2'd0, 32'h0F, 4'h1, rd, t2);
    checkOutput("push spacing", t2 - t1, 32'd2);
    wait_cycle(t1 + 25);
    for (int k = 0; k < 20; k++)
      checkOutput($sformatf("pair bit%0d", k),
                  {31'b0, txlog[t1 + 2 + k]}, {31'b0, pair_line[k]});
    checkOutput("pair idle after", {31'b0, txlog[t1 + 22]}, 32'h1);

    // Interrupt around a single frame
    applyStimulus(1'b1, 2'd2, 32'h3, 4'h1, rd, t0);
    applyStimulus(1'b1, 2'd0, 32'h00, 4'h1, rd, t3);
    wait_cycle(t3 + 16);
    checkOutput("irq before frame", {31'b0, irqlog[t3 + 1]}, 32'h1);
    checkOutput("irq frame start", {31'b0, irqlog[t3 + 2]}, 32'h0);
    checkOutput("irq last frame cyc", {31'b0, irqlog[t3 + 12]}, 32'h0);
    checkOutput("irq after stop", {31'b0, irqlog[t3 + 13]}, 32'h1);
    applyStimulus(1'b1, 2'd2, 32'h1, 4'h1, rd, t4);
    wait_cycle(t4 + 4);
    checkOutput("irq still set", {31'b0, irqlog[t4 + 1]}, 32'h1);
    checkOutput("irq disabled", {31'b0, irqlog[t4 + 2]}, 32'h0);

    // Overflow: count 8 (0x80) | overflow (0x08) | full (0x02)
    applyStimulus(1'b1, 2'd2, 32'h0, 4'h1, rd, t0);
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 2'd0, 32'h10 + i, 4'h1, rd, t0);
    applyStimulus(1'b0, 2'd1, 32'h0, 4'hF, rd, t0);
    checkOutput("STATUS overflow", rd, 32'h0000_008A);
    applyStimulus(1'b0, 2'd1, 32'h0, 4'hF, rd, t0);
    checkOutput("STATUS after clear", rd, 32'h0000_0082);

    // Reset in the middle of data bit 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 2'd0, 32'h11 * i, 4'h1, rd, t0);
    applyStimulus(1'b1, 2'd2, 32'h1, 4'h1, rd, tc);
    wait_cycle(tc + 19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("bit3 before reset", {31'b0, txlog[tc + 18]}, 32'h0);
    applyStimulus(1'b0, 2'd1, 32'h0, 4'hF, rd, t0);
    checkOutput("STATUS after reset", rd, 32'h0000_0001);
    wait_cycle(tc + 81);
    checkOutput("tx after reset", {31'b0, txlog[tc + 20]}, 32'h1);
    zeros = 0;
    for (int i = tc + 20; i < tc + 80; i++)
      if (txlog[i] !== 1'b1) zeros++;
    checkOutput("no frame after reset", zeros, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
